// File: rtl/audio_pdm_out.sv
// Audio output stage: DC blocker, volume and mute-ramp gain, saturation and a
// first-order sigma-delta modulator driving a 1-bit PDM pin plus amp shutdown.
module audio_pdm_out #(
    parameter int DEPTH      = 16,
    parameter int DC_SHIFT   = 8,
    parameter int RAMP_SHIFT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [DEPTH-1:0] sample,
    input  logic [3:0]       volume,
    output logic             pdm,
    output logic             aud_sd,
    output logic             clip
);
    localparam int YW = DEPTH + 2;
    localparam int SW = YW + 2;
    localparam int PW = YW + 14;
    localparam int CW = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;

    localparam logic [DEPTH-1:0]     MID   = {1'b1, {(DEPTH-1){1'b0}}};
    localparam logic signed [SW-1:0] MID_S = SW'(2 ** (DEPTH - 1));
    localparam logic signed [SW-1:0] Y_MAX = SW'((2 ** (YW - 1)) - 1);
    localparam logic signed [SW-1:0] Y_MIN = SW'(-(2 ** (YW - 1)));
    localparam logic signed [YW-1:0] S_MAX = YW'((2 ** (DEPTH - 1)) - 1);
    localparam logic signed [YW-1:0] S_MIN = YW'(-(2 ** (DEPTH - 1)));

    typedef enum logic [1:0] {S_OFF, S_RAMP_UP, S_ON, S_RAMP_DOWN} state_t;

    state_t                 state_q, state_d;
    logic [8:0]             ramp_q, ramp_d;
    logic [CW-1:0]          pre_q, pre_d;
    logic                   aud_sd_q, aud_sd_d;
    logic [DEPTH-1:0]       x_prev_q, x_prev_d;
    logic signed [YW-1:0]   y_q, y_d;
    logic signed [YW-1:0]   p_q, p_d;
    logic [DEPTH-1:0]       u_reg_q, u_reg_d;
    logic                   clip_q, clip_d;
    logic [DEPTH-1:0]       acc_q, acc_d;
    logic                   pdm_q, pdm_d;

    logic signed [SW-1:0]   x_ext, xp_ext, y_ext, y_sum;
    logic signed [PW-1:0]   y_w, g_w, r_w, prod;
    logic [4:0]             vol_p1;
    logic [DEPTH-1:0]       s_w;
    logic [DEPTH:0]         mod_sum;
    logic                   step;

    // Stage 1: optional DC blocker, y saturates at its own width
    always_comb begin
        x_ext  = {{(SW-DEPTH){1'b0}}, sample};
        xp_ext = {{(SW-DEPTH){1'b0}}, x_prev_q};
        y_ext  = {{(SW-YW){y_q[YW-1]}}, y_q};
        if (DC_SHIFT == 0) begin
            y_sum = x_ext - MID_S;
        end else begin
            y_sum = x_ext - xp_ext + y_ext - (y_ext >>> DC_SHIFT);
        end
        y_d      = y_q;
        x_prev_d = x_prev_q;
        if (sample_valid) begin
            x_prev_d = sample;
            if (y_sum > Y_MAX)      y_d = Y_MAX[YW-1:0];
            else if (y_sum < Y_MIN) y_d = Y_MIN[YW-1:0];
            else                    y_d = y_sum[YW-1:0];
        end
    end

    // Stage 2: full-width gain product; |p| never exceeds |y| so YW bits hold it
    always_comb begin
        vol_p1 = {1'b0, volume} + 5'd1;
        y_w    = {{(PW-YW){y_q[YW-1]}}, y_q};
        g_w    = {{(PW-5){1'b0}}, vol_p1};
        r_w    = {{(PW-9){1'b0}}, ramp_q};
        prod   = y_w * g_w * r_w;
        p_d    = YW'(prod >>> 12);
    end

    // Stage 3: saturate to DEPTH and convert to offset binary
    always_comb begin
        clip_d = 1'b0;
        s_w    = p_q[DEPTH-1:0];
        if (p_q > S_MAX) begin
            s_w    = S_MAX[DEPTH-1:0];
            clip_d = 1'b1;
        end else if (p_q < S_MIN) begin
            s_w    = S_MIN[DEPTH-1:0];
            clip_d = 1'b1;
        end
        u_reg_d = {~s_w[DEPTH-1], s_w[DEPTH-2:0]};
    end

    always_comb begin
        mod_sum = {1'b0, acc_q} + {1'b0, u_reg_q};
        acc_d   = '0;
        pdm_d   = 1'b0;
        if (state_q != S_OFF) begin
            acc_d = mod_sum[DEPTH-1:0];
            pdm_d = mod_sum[DEPTH];
        end
    end

    // Ramp FSM; an en change wins over a coincident prescaler step
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        pre_d   = pre_q + 1'b1;
        step    = (RAMP_SHIFT == 0) || (pre_q == '1);
        case (state_q)
            S_OFF: begin
                ramp_d = '0;
                if (en) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!en) begin
                    state_d = S_RAMP_DOWN;
                end else if (ramp_q == 9'd256) begin
                    state_d = S_ON;
                end else if (step) begin
                    ramp_d = ramp_q + 9'd1;
                    if (ramp_q == 9'd255) state_d = S_ON;
                end
            end
            S_ON: begin
                ramp_d = 9'd256;
                if (!en) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (en) begin
                    state_d = S_RAMP_UP;
                end else if (ramp_q == 9'd0) begin
                    state_d = S_OFF;
                end else if (step) begin
                    ramp_d = ramp_q - 9'd1;
                    if (ramp_q == 9'd1) state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
        if (state_d != state_q) pre_d = '0;
        aud_sd_d = (state_d != S_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            ramp_q   <= '0;
            pre_q    <= '0;
            aud_sd_q <= 1'b0;
            x_prev_q <= MID;
            y_q      <= '0;
            p_q      <= '0;
            u_reg_q  <= MID;
            clip_q   <= 1'b0;
            acc_q    <= '0;
            pdm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ramp_q   <= ramp_d;
            pre_q    <= pre_d;
            aud_sd_q <= aud_sd_d;
            x_prev_q <= x_prev_d;
            y_q      <= y_d;
            p_q      <= p_d;
            u_reg_q  <= u_reg_d;
            clip_q   <= clip_d;
            acc_q    <= acc_d;
            pdm_q    <= pdm_d;
        end
    end

    assign pdm    = pdm_q;
    assign aud_sd = aud_sd_q;
    assign clip   = clip_q;
endmodule

// File: tb/tb_audio_pdm_out.sv
// Bench for audio_pdm_out: two instances (DC blocker bypassed / DC_SHIFT=4)
// share stimulus; per-strobe expectations are queued and retired on their due cycle.
module tb_audio_pdm_out;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'h80;
    logic [3:0] volume = 4'd15;
    logic       pdm0, aud_sd0, clip0;
    logic       pdm4, aud_sd4, clip4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int y0m = 0;
    int y4m = 0;
    int xp4m = 128;
    int vol_m = 15;

    typedef struct {
        int   due;
        bit   which;
        int   u;
        int   c;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    audio_pdm_out #(.DEPTH(8), .DC_SHIFT(0), .RAMP_SHIFT(2)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample(sample), .volume(volume),
        .pdm(pdm0), .aud_sd(aud_sd0), .clip(clip0)
    );

    audio_pdm_out #(.DEPTH(8), .DC_SHIFT(4), .RAMP_SHIFT(2)) dut4 (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample(sample), .volume(volume),
        .pdm(pdm4), .aud_sd(aud_sd4), .clip(clip4)
    );

    function automatic int exp_p(int y, int vol, int rmp);
        return (y * (vol + 1) * rmp) >>> 12;
    endfunction

    function automatic int exp_u(int y, int vol, int rmp);
        int p;
        p = exp_p(y, vol, rmp);
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return p + 128;
    endfunction

    function automatic int exp_c(int y, int vol, int rmp);
        int p;
        p = exp_p(y, vol, rmp);
        return (p > 127 || p < -128) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.which) begin
                chk("u_reg_dc4", 32'(dut4.u_reg_q), e.u);
                chk("clip_dc4", 32'(clip4), e.c);
            end else begin
                chk("u_reg_dc0", 32'(dut0.u_reg_q), e.u);
                chk("clip_dc0", 32'(clip0), e.c);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_both(input int due);
        exp_t e;
        e.due = due; e.which = 1'b0;
        e.u = exp_u(y0m, vol_m, 256); e.c = exp_c(y0m, vol_m, 256);
        sbq.push_back(e);
        e.which = 1'b1;
        e.u = exp_u(y4m, vol_m, 256); e.c = exp_c(y4m, vol_m, 256);
        sbq.push_back(e);
    endtask

    // One-cycle strobe; gain path assumed fully unmuted (ramp=256)
    task automatic strobe(input logic [7:0] s);
        int yn;
        sample = s;
        sample_valid = 1'b1;
        y0m = int'(s) - 128;
        yn = y4m + int'(s) - xp4m - (y4m >>> 4);
        if (yn > 511) yn = 511;
        if (yn < -512) yn = -512;
        y4m = yn;
        xp4m = int'(s);
        push_both(cyc + 3);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic set_vol(input logic [3:0] v);
        volume = v;
        vol_m = int'(v);
        push_both(cyc + 2);
        ticks(4);
    endtask

    task automatic count_ones(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            n += int'(pdm0);
        end
    endtask

    initial begin
        int n;
        int k;

        for (int i = 0; i < 3; i++) begin
            sample = 8'hFF;
            sample_valid = (i % 2 == 0);
            tick();
            chk("rst_pdm", 32'(pdm0), 0);
            chk("rst_aud_sd", 32'(aud_sd0), 0);
            chk("rst_aud_sd4", 32'(aud_sd4), 0);
            chk("rst_clip", 32'(clip0), 0);
            chk("rst_u_reg", 32'(dut0.u_reg_q), 32'h80);
        end
        rst = 1'b0; en = 1'b0; sample_valid = 1'b0; sample = 8'h80;
        tick();
        chk("off_aud_sd", 32'(aud_sd0), 0);

        en = 1'b1;
        tick();
        chk("up_aud_sd", 32'(aud_sd0), 1);
        chk("up_ramp0", 32'(dut0.ramp_q), 0);
        ticks(1023);
        chk("up_ramp255", 32'(dut0.ramp_q), 255);
        tick();
        chk("up_ramp256", 32'(dut0.ramp_q), 256);
        ticks(8);
        chk("on_ramp_hold", 32'(dut0.ramp_q), 256);
        chk("on_aud_sd4", 32'(aud_sd4), 1);

        strobe(8'hC0);
        ticks(4);
        count_ones(n);
        chk_range("pdm_density_c0", n, 191, 193);
        strobe(8'h80);
        ticks(4);
        count_ones(n);
        chk_range("pdm_density_80", n, 127, 129);

        strobe(8'hC0);
        ticks(4);
        set_vol(4'd0);
        set_vol(4'd7);
        set_vol(4'd15);

        strobe(8'h00);
        k = 0;
        while (y4m != 0 && k < 200) begin
            strobe(8'h00);
            k++;
        end
        ticks(4);
        strobe(8'hFF);
        strobe(8'h80);
        for (int i = 0; i < 6; i++) strobe(8'hFF);
        ticks(4);
        chk("sb_empty", 32'(sbq.size()), 0);

        en = 1'b0;
        ticks(1024);
        chk("down_ramp1", 32'(dut0.ramp_q), 1);
        chk("down_aud_sd1", 32'(aud_sd0), 1);
        tick();
        chk("down_ramp0", 32'(dut0.ramp_q), 0);
        chk("down_aud_sd0", 32'(aud_sd0), 0);
        ticks(4);
        chk("off_pdm", 32'(pdm0), 0);

        en = 1'b1;
        ticks(401);
        chk("mid_ramp100", 32'(dut0.ramp_q), 100);
        en = 1'b0;
        tick();
        chk("rev_ramp100", 32'(dut0.ramp_q), 100);
        chk("rev_aud_sd", 32'(aud_sd0), 1);
        ticks(399);
        chk("rev_ramp1", 32'(dut0.ramp_q), 1);
        tick();
        chk("rev_ramp0", 32'(dut0.ramp_q), 0);
        chk("rev_aud_sd0", 32'(aud_sd0), 0);

        en = 1'b1;
        ticks(201);
        chk("re_ramp50", 32'(dut0.ramp_q), 50);
        rst = 1'b1;
        tick();
        chk("mid_rst_ramp", 32'(dut0.ramp_q), 0);
        chk("mid_rst_aud_sd", 32'(aud_sd0), 0);
        chk("mid_rst_u_reg", 32'(dut0.u_reg_q), 32'h80);
        chk("mid_rst_pdm", 32'(pdm0), 0);
        chk("mid_rst_clip", 32'(clip0), 0);
        rst = 1'b0;
        tick();
        chk("restart_aud_sd", 32'(aud_sd0), 1);
        chk("restart_ramp0", 32'(dut0.ramp_q), 0);
        ticks(4);
        chk("restart_ramp1", 32'(dut0.ramp_q), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
